// File: rtl/lcd_pkg.sv
// lcd_pkg: shared ASCII/command constants and formatter state encoding.
package lcd_pkg;
  localparam logic [7:0] CH_PLUS   = 8'h2B;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CMD_LINE2 = 8'hC0;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  typedef enum logic [2:0] {IDLE, CONV, CMD, SIGN, DIGIT} state_t;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: W-cycle double-dabble binary to BCD; done is high during the final iteration.
module bin2bcd_seq #(
  parameter int W = 16,
  parameter int D = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           done,
  output logic [4*D-1:0] bcd
);
  localparam int CW = $clog2(W);
  logic [W-1:0] sh;
  logic [CW-1:0] cnt;
  logic run;
  logic [4*D-1:0] adj;
  for (genvar i = 0; i < D; i++) begin : g_adj
    assign adj[4*i+:4] = (bcd[4*i+:4] >= 4'd5) ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
  end
  assign done = run && cnt == CW'(W-1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh  <= '0;
      bcd <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      sh  <= bin;
      bcd <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      {bcd, sh} <= {adj, sh} << 1;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end
endmodule

// File: rtl/lcd_value_formatter.sv
// lcd_value_formatter: signed value -> "+00000" LCD field byte stream (cursor cmd, sign, digits).
// LCD_FMT_LEADING_BLANK_EN: emit leading zero digits (except the last) as spaces.
module lcd_value_formatter
  import lcd_pkg::*;
#(
  parameter int         DATA_W     = 16,
  parameter int         NUM_DIGITS = 5,
  parameter logic [7:0] FIELD_CMD  = 8'hCA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_rs,
  output logic              busy
);
  state_t state, nxt;
  logic sign, start, done, blank;
  logic [2:0] idx;
  logic [3:0] nib;
  logic [DATA_W-1:0] mag;
  logic [4*NUM_DIGITS-1:0] bcd;
  assign start = in_valid && state == IDLE;
  assign mag   = in_value[DATA_W-1] ? -in_value : in_value;
  assign busy  = state != IDLE;
  assign nib   = bcd[{idx, 2'b00}+:4];
`ifdef LCD_FMT_LEADING_BLANK_EN
  assign blank = idx != 3'd0 && (bcd >> {idx, 2'b00}) == '0;
`else
  assign blank = 1'b0;
`endif
  bin2bcd_seq #(.W(DATA_W), .D(NUM_DIGITS)) u_conv (
    .clk(clk), .rst(rst), .start(start), .bin(mag), .done(done), .bcd(bcd)
  );
  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_rs    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = CONV;
      end
      CONV: if (done) nxt = CMD;
      CMD: begin
        out_valid = 1'b1;
        out_data  = FIELD_CMD;
        if (out_ready) nxt = SIGN;
      end
      SIGN: begin
        out_valid = 1'b1;
        out_rs    = 1'b1;
        out_data  = sign ? CH_MINUS : CH_PLUS;
        if (out_ready) nxt = DIGIT;
      end
      DIGIT: begin
        out_valid = 1'b1;
        out_rs    = 1'b1;
        out_data  = blank ? CH_SPACE : CH_ZERO + {4'h0, nib};
        if (out_ready && idx == 3'd0) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sign  <= 1'b0;
      idx   <= '0;
    end else begin
      state <= nxt;
      if (start) sign <= in_value[DATA_W-1];
      if (state == SIGN && out_ready) idx <= 3'(NUM_DIGITS - 1);
      else if (state == DIGIT && out_ready && idx != 3'd0) idx <= idx - 3'd1;
    end
  end
endmodule

// File: tb/tb_lcd_value_formatter.sv
// tb_lcd_value_formatter: directed self-checking bench; honours LCD_FMT_LEADING_BLANK_EN.
module tb_lcd_value_formatter;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] in_value = '0;
  logic in_ready, out_valid, out_rs, busy;
  logic [7:0] out_data;
  int n_cmp = 0, n_err = 0;
`ifdef LCD_FMT_LEADING_BLANK_EN
  localparam logic [7:0] LZ = 8'h20;
`else
  localparam logic [7:0] LZ = 8'h30;
`endif
  lcd_value_formatter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rs(out_rs), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [15:0] v);
    int k = 0;
    while (!in_ready && k < 60) begin @(negedge clk); k++; end
    check("send_ready", in_ready, 1);
    in_valid = 1'b1;
    in_value = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic field(input string tag, input logic [55:0] e, input bit stall, output int lat);
    lat = 0;
    for (int i = 0; i < 7; i++) begin
      int k = 0;
      while (!out_valid && k < 40) begin @(negedge clk); k++; end
      if (i == 0) lat = k;
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_data"}, out_data, e[55-8*i-:8]);
      check({tag, "_rs"}, out_rs, (i != 0));
      check({tag, "_busy"}, busy, 1);
      if (stall) begin
        logic [7:0] d = out_data;
        repeat (2) begin
          @(negedge clk);
          check({tag, "_stall_valid"}, out_valid, 1);
          check({tag, "_stall_data"}, out_data, d);
          check({tag, "_stall_rs"}, out_rs, (i != 0));
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (stall) out_ready = 1'b0;
    end
    check({tag, "_end_valid"}, out_valid, 0);
    check({tag, "_end_ready"}, in_ready, 1);
  endtask
  initial begin
    int lat;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_rs", out_rs, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    send(16'd0);
    check("conv_in_ready", in_ready, 0);
    field("zero", {8'hCA, 8'h2B, LZ, LZ, LZ, LZ, 8'h30}, 0, lat);
    check("zero_latency", lat, 16);
    send(16'h8000);
    field("min", {8'hCA, 8'h2D, 8'h33, 8'h32, 8'h37, 8'h36, 8'h38}, 0, lat);
    send(16'd32767);
    field("max", {8'hCA, 8'h2B, 8'h33, 8'h32, 8'h37, 8'h36, 8'h37}, 0, lat);
    send(-16'sd42);
    field("neg42", {8'hCA, 8'h2D, LZ, LZ, LZ, 8'h34, 8'h32}, 0, lat);
    out_ready = 1'b0;
    send(16'd12345);
    field("stall", {8'hCA, 8'h2B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35}, 1, lat);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_value = 16'd5;
    @(negedge clk);
    in_value = 16'd99;
    field("hold5", {8'hCA, 8'h2B, LZ, LZ, LZ, LZ, 8'h35}, 0, lat);
    @(negedge clk);
    in_valid = 1'b0;
    check("hold_accepted", busy, 1);
    field("hold99", {8'hCA, 8'h2B, LZ, LZ, LZ, 8'h39, 8'h39}, 0, lat);
    send(16'd1234);
    repeat (5) @(negedge clk);
    check("conv_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_conv_busy", busy, 0);
    check("arst_conv_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst1_ready", in_ready, 1);
    send(16'd1234);
    begin
      int k = 0;
      while (!out_valid && k < 40) begin @(negedge clk); k++; end
    end
    repeat (4) @(negedge clk);
    check("digit2_data", out_data, 8'h32);
    check("digit2_valid", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_digit_valid", out_valid, 0);
    check("arst_digit_data", out_data, 8'h00);
    check("arst_digit_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst2_ready", in_ready, 1);
    check("post_rst2_valid", out_valid, 0);
    send(16'd7);
    field("seven", {8'hCA, 8'h2B, LZ, LZ, LZ, LZ, 8'h37}, 0, lat);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
